// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the three result producers (ALU, MDU, MEM) and the
// register-file write ports.
//   slave  : arbiter side. It takes the stall, valid, dest and data signals,
//            and drives the readies and both register-file write ports.
//   master : producer/register-file side, with all directions reversed.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              wb_stall;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mdu_valid;
    logic [ADDR_W-1:0] mdu_dest;
    logic [DATA_W-1:0] mdu_lo;
    logic [DATA_W-1:0] mdu_hi;
    logic              mdu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_dest;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic [1:0]        registerWrite;
    logic [ADDR_W-1:0] regWriteLocal;
    logic [DATA_W-1:0] dataWrite;
    logic [DATA_W-1:0] r0Write;
    logic              err_r0_conflict;

    modport slave (
        input  wb_stall,
        input  alu_valid, alu_dest, alu_data,
        input  mdu_valid, mdu_dest, mdu_lo, mdu_hi,
        input  mem_valid, mem_dest, mem_data,
        output alu_ready, mdu_ready, mem_ready,
        output registerWrite, regWriteLocal, dataWrite, r0Write, err_r0_conflict
    );

    modport master (
        output wb_stall,
        output alu_valid, alu_dest, alu_data,
        output mdu_valid, mdu_dest, mdu_lo, mdu_hi,
        output mem_valid, mem_dest, mem_data,
        input  alu_ready, mdu_ready, mem_ready,
        input  registerWrite, regWriteLocal, dataWrite, r0Write, err_r0_conflict
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler for the 16x16 register file.
// Three producers share the general write port: ALU, MDU and MEM.
// The MDU high result always goes to the dedicated R0 port.
// Each accepted request produces exactly one registered write cycle, one
// clock after acceptance.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : regfile_wb_arbiter_if.slave. It carries the stall input, the
//              three valid/ready request channels, the combinational readies,
//              and the registered outputs registerWrite, regWriteLocal,
//              dataWrite, r0Write and err_r0_conflict.
// Parameters:
//   RR_EN    : 1 selects round-robin arbitration; 0 selects fixed priority,
//              ALU > MDU > MEM.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned RR_EN  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    regfile_wb_arbiter_if.slave   bus
);

    localparam int unsigned NSRC = 3;
    localparam int unsigned WE_W = 2;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MDU = 2'd1,
        SRC_MEM = 2'd2
    } src_e;

    src_e              rr_ptr_q, rr_ptr_d;
    logic [NSRC-1:0]   req;
    logic [NSRC-1:0]   gnt;
    logic [WE_W-1:0]   we_q, we_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] r0_q, r0_d;
    logic              err_q, err_d;

    assign req = {bus.mem_valid, bus.mdu_valid, bus.alu_valid};

    // One-hot grant. It is forced to zero during reset and stall, so the
    // readies drop combinationally.
    always_comb begin
        gnt = '0;
        if (reset_n && !bus.wb_stall) begin
            if (RR_EN != 0) begin
                case (rr_ptr_q)
                    SRC_MDU: begin
                        if      (req[1]) gnt = 3'b010;
                        else if (req[2]) gnt = 3'b100;
                        else if (req[0]) gnt = 3'b001;
                    end
                    SRC_MEM: begin
                        if      (req[2]) gnt = 3'b100;
                        else if (req[0]) gnt = 3'b001;
                        else if (req[1]) gnt = 3'b010;
                    end
                    default: begin
                        if      (req[0]) gnt = 3'b001;
                        else if (req[1]) gnt = 3'b010;
                        else if (req[2]) gnt = 3'b100;
                    end
                endcase
            end else begin
                if      (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
            end
        end
    end

    // Next-state logic. The data and index registers hold their values when
    // there is no grant; only the write enables and the error flag fall back
    // to zero.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        we_d     = '0;
        idx_d    = idx_q;
        data_d   = data_q;
        r0_d     = r0_q;
        err_d    = 1'b0;
        if (gnt[0]) begin
            we_d     = 2'b01;
            idx_d    = bus.alu_dest;
            data_d   = bus.alu_data;
            rr_ptr_d = SRC_MDU;
        end else if (gnt[1]) begin
            r0_d     = bus.mdu_hi;
            rr_ptr_d = SRC_MEM;
            if (bus.mdu_dest != ADDR_W'(0)) begin
                we_d   = 2'b11;
                idx_d  = bus.mdu_dest;
                data_d = bus.mdu_lo;
            end else begin
                // If dest is R0, only the R0 port writes and the low result
                // is discarded.
                we_d  = 2'b10;
                err_d = 1'b1;
            end
        end else if (gnt[2]) begin
            we_d     = 2'b01;
            idx_d    = bus.mem_dest;
            data_d   = bus.mem_data;
            rr_ptr_d = SRC_ALU;
        end
        if (RR_EN == 0) begin
            rr_ptr_d = SRC_ALU;
        end
    end

    // State and output registers. Reset clears any pending write at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= SRC_ALU;
            we_q     <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            r0_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            r0_q     <= r0_d;
            err_q    <= err_d;
        end
    end

    assign bus.alu_ready       = gnt[0];
    assign bus.mdu_ready       = gnt[1];
    assign bus.mem_ready       = gnt[2];
    assign bus.registerWrite   = we_q;
    assign bus.regWriteLocal   = idx_q;
    assign bus.dataWrite       = data_q;
    assign bus.r0Write         = r0_q;
    assign bus.err_r0_conflict = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic clk;
    logic reset_n;
    int   tests_run;
    int   tests_failed;

    regfile_wb_arbiter_if #(.DATA_W(16), .ADDR_W(4)) b1 ();
    regfile_wb_arbiter_if #(.DATA_W(16), .ADDR_W(4)) b0 ();

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .RR_EN(1)) u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b1)
    );

    regfile_wb_arbiter #(.DATA_W(16), .ADDR_W(4), .RR_EN(0)) u_fp (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (b0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b1.wb_stall = 1'b0; b1.alu_valid = 1'b0; b1.mdu_valid = 1'b0; b1.mem_valid = 1'b0;
        b1.alu_dest = '0; b1.alu_data = '0; b1.mdu_dest = '0; b1.mdu_lo = '0; b1.mdu_hi = '0;
        b1.mem_dest = '0; b1.mem_data = '0;
        b0.wb_stall = 1'b0; b0.alu_valid = 1'b0; b0.mdu_valid = 1'b0; b0.mem_valid = 1'b0;
        b0.alu_dest = '0; b0.alu_data = '0; b0.mdu_dest = '0; b0.mdu_lo = '0; b0.mdu_hi = '0;
        b0.mem_dest = '0; b0.mem_data = '0;
    endtask

    task automatic test_reset();
        idle_all();
        reset_n = 1'b0;
        b1.alu_valid = 1'b1;
        b1.alu_dest  = 4'd5;
        tick();
        tick();
        tests_run++;
        if (b1.alu_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_ready: got %b expected 0", b1.alu_ready);
        end
        tests_run++;
        if ({b1.registerWrite, b0.registerWrite} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_we: got %b/%b expected 00/00", b1.registerWrite, b0.registerWrite);
        end
        tests_run++;
        if ({b1.regWriteLocal, b1.dataWrite, b1.r0Write, b1.err_r0_conflict} !== 37'd0) begin
            tests_failed++; $display("FAIL reset_regs: got idx=%h data=%h r0=%h err=%b expected zeros",
                b1.regWriteLocal, b1.dataWrite, b1.r0Write, b1.err_r0_conflict);
        end
        b1.alu_valid = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_alu_single();
        b1.alu_valid = 1'b1; b1.alu_dest = 4'd5; b1.alu_data = 16'h1234;
        @(negedge clk);
        tests_run++;
        if (b1.alu_ready !== 1'b1) begin
            tests_failed++; $display("FAIL alu_ready: got %b expected 1", b1.alu_ready);
        end
        tick();
        b1.alu_valid = 1'b0;
        tests_run++;
        if (b1.registerWrite !== 2'b01 || b1.regWriteLocal !== 4'd5 || b1.dataWrite !== 16'h1234) begin
            tests_failed++; $display("FAIL alu_write: got we=%b idx=%0d data=%h expected 01/5/1234",
                b1.registerWrite, b1.regWriteLocal, b1.dataWrite);
        end
        tick();
        tests_run++;
        if (b1.registerWrite !== 2'b00 || b1.dataWrite !== 16'h1234) begin
            tests_failed++; $display("FAIL alu_idle: got we=%b data=%h expected 00/1234",
                b1.registerWrite, b1.dataWrite);
        end
    endtask

    task automatic test_mdu();
        b1.mdu_valid = 1'b1; b1.mdu_dest = 4'd3; b1.mdu_lo = 16'h00AA; b1.mdu_hi = 16'hBB00;
        @(negedge clk);
        tests_run++;
        if (b1.mdu_ready !== 1'b1) begin
            tests_failed++; $display("FAIL mdu_ready: got %b expected 1", b1.mdu_ready);
        end
        tick();
        b1.mdu_valid = 1'b0;
        tests_run++;
        if (b1.registerWrite !== 2'b11 || b1.regWriteLocal !== 4'd3 || b1.dataWrite !== 16'h00AA ||
            b1.r0Write !== 16'hBB00 || b1.err_r0_conflict !== 1'b0) begin
            tests_failed++; $display("FAIL mdu_write: got we=%b idx=%0d data=%h r0=%h err=%b expected 11/3/00aa/bb00/0",
                b1.registerWrite, b1.regWriteLocal, b1.dataWrite, b1.r0Write, b1.err_r0_conflict);
        end
    endtask

    task automatic test_mdu_r0();
        b1.mdu_valid = 1'b1; b1.mdu_dest = 4'd0; b1.mdu_lo = 16'h5555; b1.mdu_hi = 16'h7777;
        tick();
        b1.mdu_valid = 1'b0;
        tests_run++;
        if (b1.registerWrite !== 2'b10 || b1.r0Write !== 16'h7777 || b1.err_r0_conflict !== 1'b1) begin
            tests_failed++; $display("FAIL mdu_r0_write: got we=%b r0=%h err=%b expected 10/7777/1",
                b1.registerWrite, b1.r0Write, b1.err_r0_conflict);
        end
        tests_run++;
        if (b1.dataWrite !== 16'h00AA || b1.regWriteLocal !== 4'd3) begin
            tests_failed++; $display("FAIL mdu_r0_lo_discard: got data=%h idx=%0d expected 00aa/3",
                b1.dataWrite, b1.regWriteLocal);
        end
        tick();
        tests_run++;
        if (b1.err_r0_conflict !== 1'b0 || b1.registerWrite !== 2'b00) begin
            tests_failed++; $display("FAIL mdu_r0_pulse: got err=%b we=%b expected 0/00",
                b1.err_r0_conflict, b1.registerWrite);
        end
    endtask

    // Pointer is at MEM here; a MEM grant with dest 0 returns it to ALU.
    task automatic test_mem_dest0();
        b1.mem_valid = 1'b1; b1.mem_dest = 4'd0; b1.mem_data = 16'hCAFE;
        @(negedge clk);
        tests_run++;
        if (b1.mem_ready !== 1'b1) begin
            tests_failed++; $display("FAIL mem_ready: got %b expected 1", b1.mem_ready);
        end
        tick();
        b1.mem_valid = 1'b0;
        tests_run++;
        if (b1.registerWrite !== 2'b01 || b1.regWriteLocal !== 4'd0 || b1.dataWrite !== 16'hCAFE) begin
            tests_failed++; $display("FAIL mem_dest0: got we=%b idx=%0d data=%h expected 01/0/cafe",
                b1.registerWrite, b1.regWriteLocal, b1.dataWrite);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_rdy;
        logic [1:0] exp_we;
        b1.alu_valid = 1'b1; b1.alu_dest = 4'd1; b1.alu_data = 16'h1111;
        b1.mdu_valid = 1'b1; b1.mdu_dest = 4'd2; b1.mdu_lo = 16'h2222; b1.mdu_hi = 16'h2BBB;
        b1.mem_valid = 1'b1; b1.mem_dest = 4'd3; b1.mem_data = 16'h3333;
        for (int i = 0; i < 6; i++) begin
            exp_rdy = (i % 3 == 0) ? 3'b001 : (i % 3 == 1) ? 3'b010 : 3'b100;
            exp_we  = (i % 3 == 1) ? 2'b11 : 2'b01;
            @(negedge clk);
            tests_run++;
            if ({b1.mem_ready, b1.mdu_ready, b1.alu_ready} !== exp_rdy) begin
                tests_failed++; $display("FAIL rr_grant[%0d]: got %b expected %b", i,
                    {b1.mem_ready, b1.mdu_ready, b1.alu_ready}, exp_rdy);
            end
            tick();
            tests_run++;
            if (b1.registerWrite !== exp_we || b1.regWriteLocal !== 4'(i % 3 + 1)) begin
                tests_failed++; $display("FAIL rr_write[%0d]: got we=%b idx=%0d expected %b/%0d", i,
                    b1.registerWrite, b1.regWriteLocal, exp_we, i % 3 + 1);
            end
        end
        b1.alu_valid = 1'b0; b1.mdu_valid = 1'b0; b1.mem_valid = 1'b0;
        tick();
        tests_run++;
        if (b1.registerWrite !== 2'b00) begin
            tests_failed++; $display("FAIL rr_drain: got %b expected 00", b1.registerWrite);
        end
    endtask

    task automatic test_fixed_priority();
        b0.alu_valid = 1'b1; b0.alu_dest = 4'd1; b0.alu_data = 16'h1111;
        b0.mdu_valid = 1'b1; b0.mdu_dest = 4'd2; b0.mdu_lo = 16'h2222; b0.mdu_hi = 16'h2BBB;
        b0.mem_valid = 1'b1; b0.mem_dest = 4'd3; b0.mem_data = 16'h3333;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if ({b0.mem_ready, b0.mdu_ready, b0.alu_ready} !== 3'b001) begin
                tests_failed++; $display("FAIL fp_grant[%0d]: got %b expected 001", i,
                    {b0.mem_ready, b0.mdu_ready, b0.alu_ready});
            end
            tick();
            tests_run++;
            if (b0.registerWrite !== 2'b01 || b0.regWriteLocal !== 4'd1) begin
                tests_failed++; $display("FAIL fp_write[%0d]: got we=%b idx=%0d expected 01/1", i,
                    b0.registerWrite, b0.regWriteLocal);
            end
        end
        b0.alu_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({b0.mem_ready, b0.mdu_ready, b0.alu_ready} !== 3'b010) begin
            tests_failed++; $display("FAIL fp_mdu_over_mem: got %b expected 010",
                {b0.mem_ready, b0.mdu_ready, b0.alu_ready});
        end
        tick();
        b0.mdu_valid = 1'b0; b0.mem_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        b1.wb_stall = 1'b1;
        b1.alu_valid = 1'b1; b1.alu_dest = 4'd7; b1.alu_data = 16'hABCD;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (b1.alu_ready !== 1'b0) begin
                tests_failed++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, b1.alu_ready);
            end
            tick();
            tests_run++;
            if (b1.registerWrite !== 2'b00) begin
                tests_failed++; $display("FAIL stall_we[%0d]: got %b expected 00", i, b1.registerWrite);
            end
        end
        b1.wb_stall = 1'b0;
        @(negedge clk);
        tests_run++;
        if (b1.alu_ready !== 1'b1) begin
            tests_failed++; $display("FAIL unstall_ready: got %b expected 1", b1.alu_ready);
        end
        tick();
        b1.alu_valid = 1'b0;
        tests_run++;
        if (b1.registerWrite !== 2'b01 || b1.regWriteLocal !== 4'd7 || b1.dataWrite !== 16'hABCD) begin
            tests_failed++; $display("FAIL unstall_write: got we=%b idx=%0d data=%h expected 01/7/abcd",
                b1.registerWrite, b1.regWriteLocal, b1.dataWrite);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        b1.alu_valid = 1'b1; b1.alu_dest = 4'd9; b1.alu_data = 16'h0F0F;
        tick();
        tests_run++;
        if (b1.registerWrite !== 2'b01) begin
            tests_failed++; $display("FAIL pre_reset_we: got %b expected 01", b1.registerWrite);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (b1.registerWrite !== 2'b00 || b1.dataWrite !== 16'h0000) begin
            tests_failed++; $display("FAIL async_reset: got we=%b data=%h expected 00/0000",
                b1.registerWrite, b1.dataWrite);
        end
        tests_run++;
        if (b1.alu_ready !== 1'b0) begin
            tests_failed++; $display("FAIL reset_mid_ready: got %b expected 0", b1.alu_ready);
        end
        b1.alu_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_alu_single();
        test_mdu();
        test_mdu_r0();
        test_mem_dest0();
        test_round_robin();
        test_fixed_priority();
        test_stall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back scheduler for the 16x16 register file.
- Shares the file's general write port (registerWrite[0] / regWriteLocal / dataWrite) between three producers: ALU, multiply/divide unit (MDU) and memory load unit (MEM).
- Routes the MDU high result to the dedicated R0 port (registerWrite[1] / r0Write).
- All write strobes are registered: one accepted request produces exactly one write cycle, one clock later.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register index width
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority ALU > MDU > MEM

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- wb_stall  input  1  pipeline hold; while high no grants are issued
- alu_valid  input  1  ALU write request
- alu_dest  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_ready  output  1  ALU request accepted this cycle (combinational)
- mdu_valid  input  1  MDU write request
- mdu_dest  input  ADDR_W  destination for low result
- mdu_lo  input  DATA_W  low result (product low / quotient)
- mdu_hi  input  DATA_W  high result (product high / remainder), always to R0
- mdu_ready  output  1  MDU request accepted (combinational)
- mem_valid  input  1  load write request
- mem_dest  input  ADDR_W  load destination
- mem_data  input  DATA_W  load data
- mem_ready  output  1  load accepted (combinational)
- registerWrite  output  2  bit1 = R0-port write enable; bit0 = general-port write enable (registered)
- regWriteLocal  output  ADDR_W  general-port index (registered)
- dataWrite  output  DATA_W  general-port data (registered)
- r0Write  output  DATA_W  R0-port data (registered)
- err_r0_conflict  output  1  one-cycle pulse: MDU request with mdu_dest==0 (registered)

Behaviour:
- Reset (async, reset_n low): registerWrite=2'b00; regWriteLocal=0; dataWrite=0; r0Write=0; err_r0_conflict=0; rr_ptr=0 (ALU). Readies are 0 while reset_n is low.
- Handshake: valid/ready. A request transfers in the cycle where valid and ready are both high. The producer holds valid and payload stable until it is accepted. Ready never depends on the same requester's payload.
- Grant rules:
  - At most one grant per cycle.
  - No grant when wb_stall=1. All readies are 0, and the next cycle's registerWrite is 2'b00.
  - RR_EN=1: candidates are searched in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3; encoding 0=ALU, 1=MDU, 2=MEM). The first valid one is granted. After a grant, rr_ptr <= granted+1 mod 3. rr_ptr is unchanged when there is no grant.
  - RR_EN=0: fixed priority ALU > MDU > MEM; rr_ptr is unused.
- Output register, updated on the clk edge following a grant:
  - ALU/MEM grant: registerWrite=2'b01; regWriteLocal=dest; dataWrite=data.
  - MDU grant, dest!=0: registerWrite=2'b11; regWriteLocal=mdu_dest; dataWrite=mdu_lo; r0Write=mdu_hi.
  - MDU grant, dest==0: registerWrite=2'b10; r0Write=mdu_hi; mdu_lo is discarded; err_r0_conflict=1 for that cycle. The two ports never both target R0.
  - No grant: registerWrite=2'b00. dataWrite, regWriteLocal and r0Write hold their last values. err_r0_conflict=0.
- Latency: exactly 1 cycle from acceptance to write-enable high. Back-to-back grants give back-to-back write cycles with no bubble.
- Dest 0 via ALU/MEM: legal, written through the general port as normal.
- Reset mid-operation: the pending registered write is cancelled immediately (registerWrite=0 asynchronously). No request is considered accepted across reset.
- Fairness: with RR_EN=1 and all three requesters continuously valid, each is granted exactly once in every 3 consecutive non-stalled cycles.

Test Plan:
- Reset, then ALU valid with dest=5, data=16'h1234 -> alu_ready=1 that cycle; next cycle registerWrite=01, regWriteLocal=5, dataWrite=16'h1234; following cycle registerWrite=00.
- MDU dest=3, lo=16'h00AA, hi=16'hBB00 -> next cycle registerWrite=11, regWriteLocal=3, dataWrite=16'h00AA, r0Write=16'hBB00, err_r0_conflict=0.
- MDU dest=0, hi=16'h7777 -> registerWrite=10, r0Write=16'h7777, err_r0_conflict pulses for 1 cycle.
- ALU, MDU and MEM all held valid for 6 cycles, RR_EN=1 -> grant sequence ALU, MDU, MEM, ALU, MDU, MEM; write enables high on 6 consecutive cycles.
- Same stimulus with RR_EN=0 -> ALU granted every cycle; MDU and MEM readies stay 0.
- wb_stall=1 for 2 cycles with ALU valid -> alu_ready=0 and registerWrite=00 throughout the stall; the grant occurs in the first cycle after wb_stall falls. Separately, assert reset_n=0 the cycle after a grant -> registerWrite drops to 00 immediately.
